taxi_arb_stream_mux: RTL

Packet-level AXI-stream multiplexer that acts as the requester/acknowledger end of an external request/grant arbiter. It drives per-port `arb_req` from input `tvalid`, takes the arbiter's registered grant, and forwards whole frames from the granted port to a single output. On the last beat of each frame it pulses `arb_ack` so an acknowledge-blocking arbiter can release the grant. It sits between multiple MAC/PHY-side stream sources and one shared downstream stream.

---
 rtl/taxi_arb_stream_mux.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/taxi_arb_stream_mux.sv
// Packet-level AXI-stream mux acting as requester/acknowledger for an external arbiter.
// Define TAXI_ARB_STREAM_MUX_SKID_EN to build the registered-ready skid output stage.
module taxi_arb_stream_mux #(
  parameter int PORTS  = 4,
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8,
  parameter int ID_W   = $clog2(PORTS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PORTS*DATA_W-1:0] s_tdata,
  input  logic [PORTS*KEEP_W-1:0] s_tkeep,
  input  logic [PORTS-1:0]        s_tvalid,
  input  logic [PORTS-1:0]        s_tlast,
  output logic [PORTS-1:0]        s_tready,
  output logic [DATA_W-1:0]       m_tdata,
  output logic [KEEP_W-1:0]       m_tkeep,
  output logic                    m_tvalid,
  output logic                    m_tlast,
  output logic [ID_W-1:0]         m_tid,
  input  logic                    m_tready,
  output logic [PORTS-1:0]        arb_req,
  output logic [PORTS-1:0]        arb_ack,
  input  logic                    arb_grant_valid,
  input  logic [ID_W-1:0]         arb_grant_index
);

  typedef enum logic [0:0] {IDLE = 1'b0, XFER = 1'b1} state_t;
  localparam logic [PORTS-1:0] ONE_HOT0 = {{(PORTS-1){1'b0}}, 1'b1};

  state_t            state;
  logic [ID_W-1:0]   sel_reg;
  logic [DATA_W-1:0] port_data [PORTS];
  logic [KEEP_W-1:0] port_keep [PORTS];
  logic [PORTS-1:0]  ready_vec;
  logic [DATA_W-1:0] sel_data;
  logic [KEEP_W-1:0] sel_keep;
  logic              sel_valid;
  logic              sel_last;
  logic              index_ok;
  logic              grant_ok;
  logic              accept;
  logic              out_free;

  for (genvar i = 0; i < PORTS; i++) begin : g_port
    assign port_data[i] = s_tdata[i*DATA_W +: DATA_W];
    assign port_keep[i] = s_tkeep[i*KEEP_W +: KEEP_W];
  end

  // Out-of-range grant indices only exist when PORTS is not a power of two.
  if (PORTS < (1 << ID_W)) begin : g_idx_chk
    localparam logic [ID_W:0] PORT_LIMIT = (ID_W+1)'(PORTS);
    assign index_ok = ({1'b0, arb_grant_index} < PORT_LIMIT);
  end else begin : g_idx_all
    assign index_ok = 1'b1;
  end

  assign sel_data  = port_data[sel_reg];
  assign sel_keep  = port_keep[sel_reg];
  assign sel_valid = s_tvalid[sel_reg];
  assign sel_last  = s_tlast[sel_reg];
  assign grant_ok  = arb_grant_valid && index_ok && s_tvalid[arb_grant_index];
  assign out_free  = !m_tvalid || m_tready;
  assign accept    = sel_valid && ready_vec[sel_reg];
  assign s_tready  = ready_vec;
  assign arb_req   = s_tvalid;
  assign arb_ack   = s_tvalid & ready_vec & s_tlast;

`ifdef TAXI_ARB_STREAM_MUX_SKID_EN
  logic [PORTS-1:0]  ready_reg;
  logic              tmp_valid;
  logic              tmp_valid_next;
  logic              tmp_last;
  logic [DATA_W-1:0] tmp_data;
  logic [KEEP_W-1:0] tmp_keep;
  logic [ID_W-1:0]   tmp_tid;
  logic              xfer_next;
  logic [ID_W-1:0]   sel_next;

  assign tmp_valid_next = out_free ? 1'b0 : (tmp_valid || accept);
  assign xfer_next      = (state == IDLE) ? grant_ok : !(accept && sel_last);
  assign sel_next       = (state == IDLE && grant_ok) ? arb_grant_index : sel_reg;
  assign ready_vec      = rst ? {PORTS{1'b0}} : ready_reg;

  // Ready is decided one cycle ahead so it never depends on the same-cycle m_tready.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_reg <= {PORTS{1'b0}};
    end else if (xfer_next && !tmp_valid_next) begin
      ready_reg <= ONE_HOT0 << sel_next;
    end else begin
      ready_reg <= {PORTS{1'b0}};
    end
  end
`else
  assign ready_vec = (state == XFER && !rst && out_free) ? (ONE_HOT0 << sel_reg) : {PORTS{1'b0}};
`endif

  // Frame FSM: latch the granted port, release it after the last-beat handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel_reg <= {ID_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (grant_ok) begin
            state   <= XFER;
            sel_reg <= arb_grant_index;
          end
        end
        XFER: begin
          if (accept && sel_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output stage; a stalled beat holds until the sink takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_tdata  <= {DATA_W{1'b0}};
      m_tkeep  <= {KEEP_W{1'b0}};
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tid    <= {ID_W{1'b0}};
`ifdef TAXI_ARB_STREAM_MUX_SKID_EN
      tmp_valid <= 1'b0;
      tmp_data  <= {DATA_W{1'b0}};
      tmp_keep  <= {KEEP_W{1'b0}};
      tmp_last  <= 1'b0;
      tmp_tid   <= {ID_W{1'b0}};
`endif
    end else begin
`ifdef TAXI_ARB_STREAM_MUX_SKID_EN
      if (out_free) begin
        if (tmp_valid) begin
          m_tdata  <= tmp_data;
          m_tkeep  <= tmp_keep;
          m_tlast  <= tmp_last;
          m_tid    <= tmp_tid;
          m_tvalid <= 1'b1;
        end else if (accept) begin
          m_tdata  <= sel_data;
          m_tkeep  <= sel_keep;
          m_tlast  <= sel_last;
          m_tid    <= sel_reg;
          m_tvalid <= 1'b1;
        end else begin
          m_tvalid <= 1'b0;
        end
      end else if (accept) begin
        tmp_data <= sel_data;
        tmp_keep <= sel_keep;
        tmp_last <= sel_last;
        tmp_tid  <= sel_reg;
      end
      tmp_valid <= tmp_valid_next;
`else
      if (out_free) begin
        if (accept) begin
          m_tdata  <= sel_data;
          m_tkeep  <= sel_keep;
          m_tlast  <= sel_last;
          m_tid    <= sel_reg;
          m_tvalid <= 1'b1;
        end else begin
          m_tvalid <= 1'b0;
        end
      end
`endif
    end
  end

endmodule
